mc_main_fsm: RTL and testbench
==============================

// Module: mc_main_fsm
// PURPOSE
//  Multicycle MIPS main controller: Moore FSM that sequences each instruction through fetch/decode/execute/mem/writeback.
//  Sits directly upstream of the ALU decoder: drives ALUOp[1:0] (00 add, 01 sub, 10 use Funct) into it, plus all datapath mux/enable controls.
//  Supports lw, sw, R-type, beq, addi, j; adds a memory-ready handshake and illegal-opcode detection.
// PARAMETERS
//  ILLEGAL_HALT  0  1: illegal opcode enters HALT until reset; 0: flag it, treat as NOP (back to FETCH)
// PORTS
//  clk         in   1  single clock, rising edge
//  reset       in   1  synchronous, active-high
//  Op          in   6  instr[31:26], valid from IR after FETCH
//  Zero        in   1  ALU zero flag (beq)
//  mem_ready   in   1  memory access completes this cycle
//  ALUOp       out  2  to alu_decoder
//  ALUSrcA     out  1  0 PC, 1 reg A
//  ALUSrcB     out  2  00 reg B, 01 const 4, 10 SignImm, 11 SignImm<<2
//  IorD        out  1  0 PC address, 1 ALUOut address
//  RegDst      out  1  0 rt, 1 rd
//  MemtoReg    out  1  0 ALUOut, 1 Data
//  PCSrc       out  2  00 ALUResult, 01 ALUOut, 10 jump target
//  IRWrite, MemWrite, RegWrite, PCEn  out 1 each  enables
//  retire      out  1  1-cycle pulse in last state of each instruction
//  illegal     out  1  1-cycle pulse in DECODE on unsupported Op
//  state       out  4  current state (debug)
// BEHAVIOUR
//  States (4-bit): FETCH0 DECODE1 MEMADR2 MEMRD3 MEMWB4 MEMWR5 EXEC6 ALUWB7 BRANCH8 ADDIEX9 ADDIWB10 JUMP11 HALT12.
//  Transitions: FETCH->DECODE when mem_ready, else hold. DECODE by Op: 23h/2Bh->MEMADR, 00h->EXEC, 04h->BRANCH,
//   08h->ADDIEX, 02h->JUMP, other->FETCH (HALT if ILLEGAL_HALT). MEMADR: 23h->MEMRD, 2Bh->MEMWR.
//   MEMRD->MEMWB when mem_ready; MEMWR->FETCH when mem_ready; EXEC->ALUWB; ADDIEX->ADDIWB;
//   MEMWB/ALUWB/ADDIWB/BRANCH/JUMP->FETCH. HALT->HALT. Encodings 13-15 -> FETCH.
//  Moore outputs, all 0 unless listed:
//   FETCH: ALUSrcB=01, IRWrite=mem_ready, PCWrite=mem_ready. DECODE: ALUSrcB=11. MEMADR/ADDIEX: ALUSrcA=1, ALUSrcB=10.
//   MEMRD: IorD=1. MEMWB: MemtoReg=1, RegWrite=1. MEMWR: IorD=1, MemWrite=1 (held until mem_ready).
//   EXEC: ALUSrcA=1, ALUOp=10. ALUWB: RegDst=1, RegWrite=1. ADDIWB: RegWrite=1.
//   BRANCH: ALUSrcA=1, ALUOp=01, PCSrc=01, Branch=1. JUMP: PCSrc=10, PCWrite=1.
//  PCEn = PCWrite | (Branch & Zero), combinational from state and Zero.
//  retire=1 in MEMWB, ALUWB, ADDIWB, BRANCH, JUMP, and MEMWR on the mem_ready cycle.
//  Latency at mem_ready=1: lw 5, sw 4, R 4, addi 4, beq 3, j 3 cycles; each mem_ready=0 cycle adds one.
//  Reset: state<=FETCH on edge; while reset=1 IRWrite, PCEn, RegWrite, MemWrite, retire, illegal forced 0,
//   other outputs at FETCH values. Reset mid-instruction aborts it; no partial writeback after reset.
//  Op sampled only in DECODE and MEMADR; Op changes elsewhere are ignored.
// STRUCTURE
//  Shared package/header: state encodings, opcode constants (OP_RTYPE 00h, OP_LW 23h, OP_SW 2Bh, OP_BEQ 04h,
//   OP_ADDI 08h, OP_J 02h), ALUOp codes (ADD 00, SUB 01, FUNCT 10).
//  Single module: state register + next-state always block + output decode always block; no sub-module.
//  Top-level control unit instantiates mc_main_fsm and alu_decoder, ALUOp wired between.
// TESTING
//  reset 3 cycles, mem_ready=1, Op=23h -> states 0,1,2,3,4; RegWrite=1 and MemtoReg=1 only in state 4; retire there.
//  Op=00h, mem_ready=1 -> 0,1,6,7; ALUOp=10 in EXEC; RegDst=1, RegWrite=1 in ALUWB; 4-cycle period.
//  Op=04h, Zero=1 then Zero=0 -> PCEn=1 in BRANCH only when Zero=1; ALUOp=01, PCSrc=01 both runs.
//  Op=2Bh, mem_ready low 3 cycles in MEMWR -> MemWrite held 4 cycles, single retire, then FETCH.
//  Op=3Fh, ILLEGAL_HALT=0 -> illegal pulse in DECODE, back to FETCH; ILLEGAL_HALT=1 -> state 12 held, no enables.
//  reset asserted in MEMRD -> next state FETCH, no RegWrite ever; enables 0 during reset cycle.

Source files
------------

// File: rtl/mc_main_fsm_pkg.sv
// Shared definitions for the multicycle MIPS main controller: state encodings,
// supported opcodes and the ALUOp codes handed to the ALU decoder.
package mc_main_fsm_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXEC    = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11,
        S_HALT    = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    function automatic logic isSupportedOp(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW)   || (op == OP_SW) ||
               (op == OP_BEQ)   || (op == OP_ADDI) || (op == OP_J);
    endfunction

endpackage

// File: rtl/mc_main_fsm.sv
// Multicycle MIPS main controller: a Moore FSM stepping each instruction through
// fetch/decode/execute/memory/writeback, with a memory-ready handshake and illegal-opcode flag.
module mc_main_fsm #(
    parameter bit ILLEGAL_HALT = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] Op,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic [1:0] ALUOp,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       IorD,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic [1:0] PCSrc,
    output logic       IRWrite,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic       PCEn,
    output logic       retire,
    output logic       illegal,
    output logic [3:0] state
);

    import mc_main_fsm_pkg::*;

    state_t r_state;
    state_t w_nextState;
    state_t w_decState;
    logic   w_pcWrite;
    logic   w_branch;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = S_FETCH;
        case (r_state)
            S_FETCH:  w_nextState = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (Op)
                    OP_LW,
                    OP_SW:    w_nextState = S_MEMADR;
                    OP_RTYPE: w_nextState = S_EXEC;
                    OP_BEQ:   w_nextState = S_BRANCH;
                    OP_ADDI:  w_nextState = S_ADDIEX;
                    OP_J:     w_nextState = S_JUMP;
                    default:  w_nextState = ILLEGAL_HALT ? S_HALT : S_FETCH;
                endcase
            end
            // Op is re-examined here; anything other than lw/sw abandons the instruction
            S_MEMADR: begin
                if (Op == OP_LW) begin
                    w_nextState = S_MEMRD;
                end else if (Op == OP_SW) begin
                    w_nextState = S_MEMWR;
                end else begin
                    w_nextState = S_FETCH;
                end
            end
            S_MEMRD:  w_nextState = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWR:  w_nextState = mem_ready ? S_FETCH : S_MEMWR;
            S_EXEC:   w_nextState = S_ALUWB;
            S_ADDIEX: w_nextState = S_ADDIWB;
            S_HALT:   w_nextState = S_HALT;
            default:  w_nextState = S_FETCH;
        endcase
    end

    // While reset is high the outputs show FETCH decoding so nothing downstream sees a stale state
    assign w_decState = reset ? S_FETCH : r_state;
    assign state      = w_decState;
    assign PCEn       = w_pcWrite | (w_branch & Zero);

    always_comb begin
        ALUOp     = ALUOP_ADD;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 2'b00;
        IorD      = 1'b0;
        RegDst    = 1'b0;
        MemtoReg  = 1'b0;
        PCSrc     = 2'b00;
        IRWrite   = 1'b0;
        MemWrite  = 1'b0;
        RegWrite  = 1'b0;
        retire    = 1'b0;
        illegal   = 1'b0;
        w_pcWrite = 1'b0;
        w_branch  = 1'b0;
        case (w_decState)
            S_FETCH: begin
                ALUSrcB   = 2'b01;
                IRWrite   = mem_ready;
                w_pcWrite = mem_ready;
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
                illegal = ~isSupportedOp(Op);
            end
            S_MEMADR,
            S_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_MEMRD: IorD = 1'b1;
            S_MEMWB: begin
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
                retire   = 1'b1;
            end
            S_MEMWR: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
                retire   = mem_ready;
            end
            S_EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
                retire   = 1'b1;
            end
            S_ADDIWB: begin
                RegWrite = 1'b1;
                retire   = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA  = 1'b1;
                ALUOp    = ALUOP_SUB;
                PCSrc    = 2'b01;
                w_branch = 1'b1;
                retire   = 1'b1;
            end
            S_JUMP: begin
                PCSrc     = 2'b10;
                w_pcWrite = 1'b1;
                retire    = 1'b1;
            end
            default: begin
            end
        endcase
        if (reset) begin
            IRWrite   = 1'b0;
            MemWrite  = 1'b0;
            RegWrite  = 1'b0;
            retire    = 1'b0;
            illegal   = 1'b0;
            w_pcWrite = 1'b0;
            w_branch  = 1'b0;
        end
    end

endmodule

// File: tb/tb_mc_main_fsm.sv
// Self-checking bench for mc_main_fsm: directed vector table, hand-written corner
// sequences and randomized stimulus checked against an instruction-level reference model.
module tb_mc_main_fsm;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] Op;
    logic       Zero;
    logic       mem_ready;

    logic [1:0] aALUOp, aALUSrcB, aPCSrc, hALUOp, hALUSrcB, hPCSrc;
    logic       aALUSrcA, aIorD, aRegDst, aMemtoReg, aIRWrite, aMemWrite, aRegWrite, aPCEn, aRetire, aIllegal;
    logic       hALUSrcA, hIorD, hRegDst, hMemtoReg, hIRWrite, hMemWrite, hRegWrite, hPCEn, hRetire, hIllegal;
    logic [3:0] aState, hState;
    logic [19:0] outA, outH;

    int nChecks = 0;
    int nPass   = 0;

    // Reference model: current state number plus the remaining states of the instruction, one per nibble
    int          mCur  [2];
    logic [15:0] mPlan [2];

    always #5 clk = ~clk;

    mc_main_fsm #(.ILLEGAL_HALT(1'b0)) dutA (
        .clk(clk), .reset(reset), .Op(Op), .Zero(Zero), .mem_ready(mem_ready),
        .ALUOp(aALUOp), .ALUSrcA(aALUSrcA), .ALUSrcB(aALUSrcB), .IorD(aIorD), .RegDst(aRegDst),
        .MemtoReg(aMemtoReg), .PCSrc(aPCSrc), .IRWrite(aIRWrite), .MemWrite(aMemWrite),
        .RegWrite(aRegWrite), .PCEn(aPCEn), .retire(aRetire), .illegal(aIllegal), .state(aState)
    );

    mc_main_fsm #(.ILLEGAL_HALT(1'b1)) dutH (
        .clk(clk), .reset(reset), .Op(Op), .Zero(Zero), .mem_ready(mem_ready),
        .ALUOp(hALUOp), .ALUSrcA(hALUSrcA), .ALUSrcB(hALUSrcB), .IorD(hIorD), .RegDst(hRegDst),
        .MemtoReg(hMemtoReg), .PCSrc(hPCSrc), .IRWrite(hIRWrite), .MemWrite(hMemWrite),
        .RegWrite(hRegWrite), .PCEn(hPCEn), .retire(hRetire), .illegal(hIllegal), .state(hState)
    );

    assign outA = {aALUOp, aALUSrcA, aALUSrcB, aIorD, aRegDst, aMemtoReg, aPCSrc,
                   aIRWrite, aMemWrite, aRegWrite, aPCEn, aRetire, aIllegal, aState};
    assign outH = {hALUOp, hALUSrcA, hALUSrcB, hIorD, hRegDst, hMemtoReg, hPCSrc,
                   hIRWrite, hMemWrite, hRegWrite, hPCEn, hRetire, hIllegal, hState};

    typedef struct {
        logic       rst;
        logic [5:0] op;
        logic       z;
        logic       mr;
        logic [3:0] st;
        logic [1:0] aluOp;
        logic [1:0] pcSrc;
        logic       rw;
        logic       mtr;
        logic       pce;
        logic       ret;
    } vec_t;

    vec_t vecs [18];

    function automatic logic legalOp(input logic [5:0] op);
        return op inside {6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h02};
    endfunction

    // Expected outputs of a given state, straight from the per-state output table
    function automatic logic [19:0] expOut(input int s, input logic rst, input logic [5:0] op,
                                           input logic z, input logic mr);
        logic [1:0] aluOp, srcB, pcSrc;
        logic srcA, iord, regDst, mtr, irw, mw, rw, pce, ret, ill;
        int es;
        aluOp = 2'b00; srcB = 2'b00; pcSrc = 2'b00;
        srcA = 1'b0; iord = 1'b0; regDst = 1'b0; mtr = 1'b0; irw = 1'b0;
        mw = 1'b0; rw = 1'b0; pce = 1'b0; ret = 1'b0; ill = 1'b0;
        es = rst ? 0 : s;
        case (es)
            0:  begin srcB = 2'b01; irw = mr; pce = mr; end
            1:  begin srcB = 2'b11; ill = ~legalOp(op); end
            2, 9: begin srcA = 1'b1; srcB = 2'b10; end
            3:  iord = 1'b1;
            4:  begin mtr = 1'b1; rw = 1'b1; ret = 1'b1; end
            5:  begin iord = 1'b1; mw = 1'b1; ret = mr; end
            6:  begin srcA = 1'b1; aluOp = 2'b10; end
            7:  begin regDst = 1'b1; rw = 1'b1; ret = 1'b1; end
            8:  begin srcA = 1'b1; aluOp = 2'b01; pcSrc = 2'b01; pce = z; ret = 1'b1; end
            10: begin rw = 1'b1; ret = 1'b1; end
            11: begin pcSrc = 2'b10; pce = 1'b1; ret = 1'b1; end
            default: begin end
        endcase
        if (rst) begin
            irw = 1'b0; pce = 1'b0;
        end
        return {aluOp, srcA, srcB, iord, regDst, mtr, pcSrc, irw, mw, rw, pce, ret, ill, 4'(es)};
    endfunction

    // Sequence of states an instruction walks after DECODE, listed low nibble first
    function automatic logic [15:0] planFor(input logic [5:0] op, input int k);
        case (op)
            6'h23:   return 16'h0432;
            6'h2B:   return 16'h0052;
            6'h00:   return 16'h0076;
            6'h04:   return 16'h0008;
            6'h08:   return 16'h00A9;
            6'h02:   return 16'h000B;
            default: return (k == 1) ? 16'h000C : 16'h0000;
        endcase
    endfunction

    task automatic modelStep(input int k, input logic rst, input logic [5:0] op, input logic mr);
        int s;
        s = mCur[k];
        if (rst) begin
            mCur[k]  = 0;
            mPlan[k] = 16'h0;
        end else if (s == 12) begin
        end else if ((s == 0 || s == 3 || s == 5) && !mr) begin
        end else if (s == 0) begin
            mCur[k] = 1;
        end else begin
            if (s == 1) mPlan[k] = planFor(op, k);
            if (s == 2) mPlan[k] = (op == 6'h23) ? 16'h0043 : (op == 6'h2B) ? 16'h0005 : 16'h0000;
            mCur[k]  = int'(mPlan[k][3:0]);
            mPlan[k] = mPlan[k] >> 4;
        end
    endtask

    task automatic checkOutput(input string name, input logic [19:0] act, input logic [19:0] exp);
        nChecks++;
        if (act !== exp) begin
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end else begin
            nPass++;
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic [5:0] op, input logic z, input logic mr);
        @(negedge clk);
        reset = rst; Op = op; Zero = z; mem_ready = mr;
        #2;
        checkOutput("modelA", outA, expOut(mCur[0], rst, op, z, mr));
        checkOutput("modelH", outH, expOut(mCur[1], rst, op, z, mr));
    endtask

    task automatic advance();
        @(posedge clk);
        modelStep(0, reset, Op, mem_ready);
        modelStep(1, reset, Op, mem_ready);
    endtask

    task automatic step(input logic rst, input logic [5:0] op, input logic z, input logic mr);
        applyStimulus(rst, op, z, mr);
        advance();
    endtask

    initial begin
        logic [5:0] opPick [7];
        reset = 1'b1; Op = 6'h00; Zero = 1'b0; mem_ready = 1'b0;
        mCur[0] = 0; mCur[1] = 0; mPlan[0] = 16'h0; mPlan[1] = 16'h0;

        // rst, op, z, mr | state, ALUOp, PCSrc, RegWrite, MemtoReg, PCEn, retire
        vecs[0]  = '{1'b1, 6'h23, 1'b0, 1'b1, 4'd0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 6'h23, 1'b0, 1'b1, 4'd0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 6'h23, 1'b0, 1'b1, 4'd0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 6'h23, 1'b0, 1'b1, 4'd0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 6'h23, 1'b0, 1'b1, 4'd1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 6'h23, 1'b0, 1'b1, 4'd2, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 6'h23, 1'b0, 1'b1, 4'd3, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 6'h23, 1'b0, 1'b1, 4'd4, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[8]  = '{1'b0, 6'h00, 1'b0, 1'b1, 4'd0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 6'h00, 1'b0, 1'b1, 4'd1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 6'h00, 1'b0, 1'b1, 4'd6, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 6'h00, 1'b0, 1'b1, 4'd7, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[12] = '{1'b0, 6'h04, 1'b1, 1'b1, 4'd0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[13] = '{1'b0, 6'h04, 1'b1, 1'b1, 4'd1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[14] = '{1'b0, 6'h04, 1'b1, 1'b1, 4'd8, 2'b01, 2'b01, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[15] = '{1'b0, 6'h04, 1'b0, 1'b1, 4'd0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[16] = '{1'b0, 6'h04, 1'b0, 1'b1, 4'd1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[17] = '{1'b0, 6'h04, 1'b0, 1'b1, 4'd8, 2'b01, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1};

        for (int i = 0; i < 18; i++) begin
            applyStimulus(vecs[i].rst, vecs[i].op, vecs[i].z, vecs[i].mr);
            checkOutput("vecState", 20'(aState), 20'(vecs[i].st));
            checkOutput("vecALUOp", 20'(aALUOp), 20'(vecs[i].aluOp));
            checkOutput("vecPCSrc", 20'(aPCSrc), 20'(vecs[i].pcSrc));
            checkOutput("vecRegWrite", 20'(aRegWrite), 20'(vecs[i].rw));
            checkOutput("vecMemtoReg", 20'(aMemtoReg), 20'(vecs[i].mtr));
            checkOutput("vecPCEn", 20'(aPCEn), 20'(vecs[i].pce));
            checkOutput("vecRetire", 20'(aRetire), 20'(vecs[i].ret));
            advance();
        end

        // sw with memory stalling three cycles in MEMWR
        step(1'b0, 6'h2B, 1'b0, 1'b1);
        step(1'b0, 6'h2B, 1'b0, 1'b1);
        step(1'b0, 6'h2B, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 6'h2B, 1'b0, (i == 3) ? 1'b1 : 1'b0);
            checkOutput("swState", 20'(aState), 20'd5);
            checkOutput("swMemWrite", 20'(aMemWrite), 20'd1);
            checkOutput("swRetire", 20'(aRetire), (i == 3) ? 20'd1 : 20'd0);
            advance();
        end
        applyStimulus(1'b0, 6'h00, 1'b0, 1'b0);
        checkOutput("swBackToFetch", 20'(aState), 20'd0);
        advance();

        // Illegal opcode: flagged in DECODE; NOP on one instance, HALT on the other
        step(1'b0, 6'h3F, 1'b0, 1'b1);
        applyStimulus(1'b0, 6'h3F, 1'b0, 1'b1);
        checkOutput("illegalPulseA", 20'(aIllegal), 20'd1);
        checkOutput("illegalPulseH", 20'(hIllegal), 20'd1);
        advance();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 6'h3F, 1'b1, 1'b1);
            if (i == 0) checkOutput("illegalNopA", 20'(aState), 20'd0);
            checkOutput("haltState", 20'(hState), 20'd12);
            checkOutput("haltEnables", 20'({hIRWrite, hMemWrite, hRegWrite, hPCEn, hRetire}), 20'd0);
            advance();
        end
        step(1'b1, 6'h00, 1'b0, 1'b1);

        // Reset while lw sits in MEMRD must abort without any writeback
        step(1'b0, 6'h23, 1'b0, 1'b1);
        step(1'b0, 6'h23, 1'b0, 1'b1);
        step(1'b0, 6'h23, 1'b0, 1'b1);
        applyStimulus(1'b0, 6'h23, 1'b0, 1'b0);
        checkOutput("memrdState", 20'(aState), 20'd3);
        advance();
        applyStimulus(1'b1, 6'h23, 1'b1, 1'b1);
        checkOutput("resetState", 20'(aState), 20'd0);
        checkOutput("resetEnables", 20'({aIRWrite, aMemWrite, aRegWrite, aPCEn, aRetire, aIllegal}), 20'd0);
        advance();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 6'h23, 1'b0, 1'b0);
            checkOutput("abortFetch", 20'(aState), 20'd0);
            checkOutput("abortNoRegWrite", 20'(aRegWrite), 20'd0);
            advance();
        end

        opPick[0] = 6'h23; opPick[1] = 6'h2B; opPick[2] = 6'h00; opPick[3] = 6'h04;
        opPick[4] = 6'h08; opPick[5] = 6'h02; opPick[6] = 6'h3F;
        for (int i = 0; i < 400; i++) begin
            logic [5:0] op;
            op = opPick[$urandom_range(0, 6)];
            if (op == 6'h3F) op = 6'($urandom_range(0, 63));
            step(($urandom_range(0, 39) == 0) ? 1'b1 : 1'b0, op,
                 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
        end
        step(1'b1, 6'h00, 1'b0, 1'b1);

        $display("[TB] %0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
